if_prefetch: RTL and testbench
==============================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction queue entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  response data valid, in request order, latency >= 1 cycle after gnt.
REQ-009 SHALL have port imem_rdata  input  32  response instruction word.
REQ-010 SHALL have port redirect  input  1  taken branch/jump from execute stage; flush.
REQ-011 SHALL have port redirect_pc  input  32  new fetch address.
REQ-012 SHALL have port stall  input  1  decode stage not accepting (StallD).
REQ-013 SHALL have port instr_valid  output  1  instr/instr_pc hold a live instruction.
REQ-014 SHALL have port instr  output  32  instruction to decode register.
REQ-015 SHALL have port instr_pc  output  32  address of instr.
REQ-016 SHALL have port instr_pc_plus4  output  32  instr_pc + 4, modulo 2^32.

Function
REQ-017 SHALL hold fetch PC register fpc; imem_addr = fpc; fpc advances by 4 on imem_req && imem_gnt.
REQ-018 SHALL assert imem_req only when outstanding + occupancy < DEPTH and redirect is low.
REQ-019 SHALL count outstanding requests (granted, response not yet received), width clog2(DEPTH)+1.
REQ-020 SHALL push {imem_rdata, pc} into queue on imem_rvalid unless that response is marked for drop; pc taken from a per-request address FIFO of depth DEPTH.
REQ-021 SHALL present queue head on instr/instr_pc with instr_valid = queue not empty; pop when instr_valid && !stall.
REQ-022 SHALL drive instr = 32'h0000_0013 (NOP) and instr_pc = fpc when instr_valid low.
REQ-023 SHALL on redirect: empty queue same edge, load fpc = redirect_pc, set drop count = outstanding (+1 if a gnt occurs that cycle), deassert imem_req that cycle.
REQ-024 SHALL discard responses while drop count > 0, decrementing per imem_rvalid, including one arriving in the redirect cycle.
REQ-025 SHALL treat simultaneous push and pop as legal when full: pop frees slot, push lands, occupancy unchanged.
REQ-026 SHALL ignore redirect_pc[1:0] (forced to 0).
REQ-027 SHALL give minimum latency of 2 cycles from gnt to instr_valid for a 1-cycle memory (rvalid cycle +1 for queue write).
REQ-028 SHALL treat stall with redirect same cycle as redirect (flush wins).
REQ-029 SHALL wrap fpc and pointers modulo their width without error.

Reset
REQ-030 SHALL on n_rst low asynchronously set fpc = RESET_PC, queue empty, outstanding = 0, drop = 0, imem_req = 0, instr_valid = 0, instr = NOP, instr_pc = RESET_PC.
REQ-031 SHALL raise imem_req in the first clk edge after n_rst deasserts; responses in flight at reset assertion are lost and memory shall be reset together.

Structure
REQ-032 SHALL take NOP_INSTR and RESET_PC default from shared package core_pkg.
REQ-033 SHALL instantiate one sub-module sync_fifo (parameterised width/depth, push/pop/flush, full/empty) used for both the instruction queue and the address FIFO.

Verification
REQ-034 Reset, 1-cycle memory, stall=0 -> addresses 0x1000_0000, 0x1000_0004, ... ; first instr_valid 2 cycles after first gnt, one instruction per cycle.
REQ-035 stall held 5 cycles with DEPTH=2 -> queue fills to 2, imem_req low while outstanding+occupancy=2, no instruction lost or duplicated after release.
REQ-036 redirect to 0x1000_0100 with 2 outstanding -> both responses dropped; next instr_pc = 0x1000_0100.
REQ-037 redirect coincident with gnt and rvalid -> rvalid word dropped, granted request dropped later; drop count reaches 0.
REQ-038 memory latency 3 cycles, random gnt -> instr stream in program order, instr_pc_plus4 = instr_pc+4.
REQ-039 n_rst asserted mid-stream -> all outputs at reset values immediately, fetch restarts at 0x1000_0000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions for the fetch front end.
// Contents:
//   NOP_INSTR        - canonical RISC-V NOP (addi x0, x0, 0)
//   RESET_PC_DEFAULT - default first fetch address after reset
//   iq_entry_t       - one instruction-queue entry {instr, pc}
//   word_align()     - clear the two byte-offset bits of an address
package core_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } iq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, first-word-fall-through read.
// Ports:
//   clk, n_rst     - clock, asynchronous active-low reset
//   flush          - empty the FIFO this edge (wins over push)
//   push / wdata   - write request; accepted when not full or popping
//   pop            - remove head; ignored when empty
//   rdata          - current head entry
//   full / empty   - occupancy flags
//   count          - occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty     = (count_q == {(AW+1){1'b0}});
  assign full      = (count_q == CNT_FULL);
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign do_pop_s  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push_s = push && (!full || do_pop_s);

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (do_push_s && !do_pop_s) begin
        count_d = count_q + CNT_ONE;
      end else if (!do_push_s && do_pop_s) begin
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch prefetcher: issues sequential word fetches, tags each
// response with its address, and queues {instr, pc} for the decode stage.
// Ports:
//   clk, n_rst                     - clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt    - fetch request handshake
//   imem_rvalid/imem_rdata         - in-order fetch responses
//   redirect/redirect_pc           - flush and restart at a new address
//   stall                          - decode not accepting this cycle
//   instr_valid/instr/instr_pc     - queue head (NOP and fetch PC when empty)
//   instr_pc_plus4                 - instr_pc + 4
module if_prefetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   SUM_LIMIT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          started_q, started_d;

  logic [CW-1:0] outstanding_s;
  logic [CW-1:0] iq_count_s;
  logic [CW:0]   inflight_s;
  logic          af_full_s, af_empty_s, iq_full_s, iq_empty_s;
  logic [31:0]   rsp_pc_s;
  iq_entry_t     iq_wdata_s, iq_head_s;
  logic          fire_s, rsp_s, drop_active_s, iq_push_s, iq_pop_s;

  // The address FIFO holds one entry per granted-but-unanswered request, so
  // its occupancy is the outstanding-request count.
  assign inflight_s    = {1'b0, outstanding_s} + {1'b0, iq_count_s};
  assign imem_req      = started_q && !redirect && !af_full_s && (inflight_s < SUM_LIMIT);
  assign imem_addr     = fpc_q;
  assign fire_s        = imem_req && imem_gnt;
  // A response with no recorded request is ignored rather than corrupting state.
  assign rsp_s         = imem_rvalid && !af_empty_s;
  assign drop_active_s = (drop_q != CNT_ZERO);
  assign iq_push_s     = rsp_s && !drop_active_s && !redirect && (!iq_full_s || iq_pop_s);
  assign instr_valid   = !iq_empty_s;
  assign iq_pop_s      = instr_valid && !stall && !redirect;
  assign iq_wdata_s    = '{instr: imem_rdata, pc: rsp_pc_s};

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_addr_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .flush (1'b0),
    .push  (fire_s),
    .pop   (rsp_s),
    .wdata (fpc_q),
    .rdata (rsp_pc_s),
    .full  (af_full_s),
    .empty (af_empty_s),
    .count (outstanding_s)
  );

  sync_fifo #(
    .WIDTH ($bits(iq_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_queue (
    .clk   (clk),
    .n_rst (n_rst),
    .flush (redirect),
    .push  (iq_push_s),
    .pop   (iq_pop_s),
    .wdata (iq_wdata_s),
    .rdata (iq_head_s),
    .full  (iq_full_s),
    .empty (iq_empty_s),
    .count (iq_count_s)
  );

  // Next fetch PC and drop count; a redirect marks every in-flight request
  // as stale except a response consumed (and discarded) this very cycle.
  always_comb begin
    fpc_d     = fpc_q;
    drop_d    = drop_q;
    started_d = 1'b1;
    if (redirect) begin
      fpc_d  = word_align(redirect_pc);
      drop_d = outstanding_s + (fire_s ? CNT_ONE : CNT_ZERO) - (rsp_s ? CNT_ONE : CNT_ZERO);
    end else begin
      if (fire_s) begin
        fpc_d = fpc_q + 32'd4;
      end else begin
        fpc_d = fpc_q;
      end
      if (rsp_s && drop_active_s) begin
        drop_d = drop_q - CNT_ONE;
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fpc_q     <= RESET_PC;
      drop_q    <= CNT_ZERO;
      started_q <= 1'b0;
    end else begin
      fpc_q     <= fpc_d;
      drop_q    <= drop_d;
      started_q <= started_d;
    end
  end

  // Decode-side view: queue head, or a NOP at the fetch PC when empty
  always_comb begin
    instr    = NOP_INSTR;
    instr_pc = fpc_q;
    if (instr_valid) begin
      instr    = iq_head_s.instr;
      instr_pc = iq_head_s.pc;
    end else begin
      instr    = NOP_INSTR;
      instr_pc = fpc_q;
    end
  end

  assign instr_pc_plus4 = instr_pc + 32'd4;

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;
  import core_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  if_prefetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: a bijective scramble of the address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    logic [31:0] r;
    r = {a[12:0], a[31:13]};
    return r ^ 32'hC3A5_0F69;
  endfunction

  // Reference state: in-order memory with pending requests, the set of
  // fetched words the decode stage is entitled to see, and the fetch PC.
  typedef struct {
    logic [31:0] pc;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       pend[$];
  logic [31:0] iq[$];
  logic [31:0] m_fpc = RPC;
  int          epoch = 0;
  bit          started = 1'b0;
  int          last_due = 0;
  int          lat = 1;
  int          first_fire = -1;
  bit          seen_valid = 1'b0;
  logic [31:0] want_first = 32'd0;
  bit          want_first_v = 1'b0;
  int          consumed = 0;

  task automatic drive_mem();
    if (n_rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memfn(pend[0].pc);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic step(input bit g, input bit s, input bit r, input logic [31:0] t);
    @(posedge clk);
    #1;
    imem_gnt    = g;
    stall       = s;
    redirect    = r;
    redirect_pc = t;
    drive_mem();
  endtask

  // Monitor / scoreboard: compares against the reference, then applies this
  // cycle's events to it.
  always @(negedge clk) begin
    mreq_t       rq;
    int          d;
    logic [31:0] exp_pc;
    bit          exp_req;
    if (!n_rst) begin
      chk("rst_imem_req", imem_req, 32'd0);
      chk("rst_instr_valid", instr_valid, 32'd0);
      chk("rst_instr", instr, NOP_INSTR);
      chk("rst_instr_pc", instr_pc, RPC);
      chk("rst_imem_addr", imem_addr, RPC);
      pend.delete();
      iq.delete();
      m_fpc        = RPC;
      started      = 1'b0;
      last_due     = 0;
      first_fire   = -1;
      seen_valid   = 1'b0;
      want_first_v = 1'b0;
    end else begin
      exp_req = started && !redirect && ((pend.size() + iq.size()) < DEPTH);
      chk("imem_req", imem_req, exp_req);
      chk("imem_addr", imem_addr, m_fpc);
      chk("instr_valid", instr_valid, iq.size() > 0);
      if (iq.size() > 0) begin
        chk("instr_pc", instr_pc, iq[0]);
        chk("instr", instr, memfn(iq[0]));
        exp_pc = iq[0];
      end else begin
        chk("nop_instr", instr, NOP_INSTR);
        chk("idle_instr_pc", instr_pc, m_fpc);
        exp_pc = m_fpc;
      end
      chk("instr_pc_plus4", instr_pc_plus4, exp_pc + 32'd4);
      if (!seen_valid && instr_valid) begin
        seen_valid = 1'b1;
        chk("first_gnt_to_valid", cyc - first_fire, 32'd2);
      end
      if (instr_valid && !stall && !redirect && iq.size() > 0) begin
        if (want_first_v) begin
          chk("post_redirect_pc", instr_pc, want_first);
          want_first_v = 1'b0;
        end
        void'(iq.pop_front());
        consumed++;
      end
      if (imem_rvalid && pend.size() > 0) begin
        rq = pend.pop_front();
        if (rq.epoch == epoch && !redirect) iq.push_back(rq.pc);
      end
      if (imem_req && imem_gnt) begin
        if (first_fire < 0) first_fire = cyc;
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pend.push_back('{m_fpc, epoch, d});
        m_fpc = m_fpc + 32'd4;
      end
      if (redirect) begin
        iq.delete();
        epoch++;
        m_fpc        = redirect_pc & 32'hFFFF_FFFC;
        want_first   = m_fpc;
        want_first_v = 1'b1;
      end
      started = 1'b1;
    end
  end

  initial begin
    bit          hit;
    logic [31:0] tgt;

    // Reset, then a 1-cycle memory with no stall.
    repeat (3) @(posedge clk);
    #1;
    n_rst    = 1'b1;
    imem_gnt = 1'b1;
    lat      = 1;
    repeat (20) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Stall for 5 cycles: queue fills and requests stop.
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("stall_full_imem_req", imem_req, 32'd0);
    chk("stall_full_instr_valid", instr_valid, 32'd1);
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Redirect with two requests outstanding.
    lat = 3;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      if (pend.size() == 2) hit = 1'b1;
    end
    chk("wait_two_outstanding", hit, 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h1000_0100);
    repeat (15) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Redirect coincident with gnt and rvalid; low address bits ignored.
    lat = 2;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge clk);
      #1;
      imem_gnt = 1'b1;
      stall    = 1'b0;
      drive_mem();
      if (imem_rvalid && pend.size() >= 2) begin
        redirect    = 1'b1;
        redirect_pc = 32'h1000_0203;
        hit         = 1'b1;
      end else begin
        redirect = 1'b0;
      end
    end
    chk("wait_redirect_with_rvalid", hit, 32'd1);
    repeat (15) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Address wrap past 2^32.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF6);
    repeat (12) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Latency 3, random gnt / stall / redirect.
    lat = 3;
    for (int i = 0; i < 300; i++) begin
      tgt = ($urandom_range(0, 1) == 0) ? (32'h1000_0000 + ($urandom & 32'h0000_0FFF))
                                        : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0, tgt);
    end

    // Random latency 1..4.
    for (int i = 0; i < 300; i++) begin
      lat = $urandom_range(1, 4);
      tgt = 32'h2000_0000 + ($urandom & 32'h0000_FFFF);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0, tgt);
    end
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Asynchronous reset mid-stream.
    lat = 1;
    @(posedge clk);
    #3;
    n_rst       = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    stall       = 1'b0;
    imem_gnt    = 1'b1;
    #1;
    chk("async_rst_imem_req", imem_req, 32'd0);
    chk("async_rst_instr_valid", instr_valid, 32'd0);
    chk("async_rst_instr", instr, NOP_INSTR);
    chk("async_rst_instr_pc", instr_pc, RPC);
    chk("async_rst_imem_addr", imem_addr, RPC);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (20) step(1'b1, 1'b0, 1'b0, 32'd0);

    chk("consumed_enough", consumed >= 150, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
